hazard_ctrl: RTL

//  Pipeline hazard controller for the 5-stage core. Drives the Execute-stage operand

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use stalls,
// branch flushes, MUL/DIV wait sequencing and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MdStartE,
  input  logic             MdDoneE,
  input  logic             CntClr,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleM,
  output logic             MdTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(MD_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              md_release;

  // Memory stage wins over Writeback; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == src)
      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ForwardA_E = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
    ForwardB_E = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
    load_use   = ResultSrcE && RD_E != 5'd0 && (RD_E == Rs1_D || RD_E == Rs2_D);
    md_release = MdDoneE || wait_cnt == WAIT_LAST;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    BubbleM    = 1'b0;
    case (state)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MD_WAIT: begin
        // Release cycle drops all stalls so the MUL/DIV result moves on to M
        if (!md_release) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          BubbleM = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      MdTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MdStartE && !MdDoneE) begin
            state    <= MD_WAIT;
            wait_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (MdDoneE) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= RUN;
            MdTimeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && StallCount != CNT_MAX)
        StallCount <= StallCount + CNT_W'(1);
      if (FlushE && FlushCount != CNT_MAX)
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule
